opl_host_bus: RTL and testbench

OPL_HOST_BUS -- requirements
Module: opl_host_bus

---
 rtl/opl2_pkg.sv | 38 +++
 rtl/opl_sync_fifo.sv | 71 +++++++
 rtl/opl_host_bus.sv | 193 +++++++++++++++++++
 tb/tb_opl_host_bus.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/opl2_pkg.sv
// Shared types and constants for the OPL host bus and register file write path.
package opl2_pkg;

    localparam int REG_FILE_DATA_WIDTH = 8;
    localparam int REG_FILE_ADDR_WIDTH = 8;
    localparam int OPL_BANK_WIDTH      = 1;

    // One register-file write as seen by the synthesis core.
    typedef struct packed {
        logic                           valid;
        logic [OPL_BANK_WIDTH-1:0]      bank;
        logic [REG_FILE_ADDR_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl_reg_wr_t;

    // One queued host write: port select, bank, and the byte written.
    typedef struct packed {
        logic                           a0;
        logic [OPL_BANK_WIDTH-1:0]      bank;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl_fifo_entry_t;

    localparam int OPL_FIFO_ENTRY_WIDTH = $bits(opl_fifo_entry_t);

    typedef enum logic [1:0] {
        RET_IDLE = 2'd0,
        RET_POP  = 2'd1,
        RET_WAIT = 2'd2
    } opl_retire_state_t;

    // Counter reload for a wait of N idle cycles. The IDLE cycle between
    // WAIT and the next POP is itself one idle cycle, so the counter only
    // covers N-1 of them; a zero wait still costs one WAIT cycle.
    function automatic int wait_reload(input int wait_cycles);
        return (wait_cycles > 0) ? wait_cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/opl_sync_fifo.sv
// Single-clock FIFO with registered, first-word-available read data.
// Pointers carry one extra bit so full and empty are distinguishable.
module opl_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign rd_data = rd_data_q;

    // Pointer advance; a write into a full queue is accepted only alongside a read.
    always_comb begin
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);
    end

    // Storage update and next head word; a write landing on the new head bypasses the array.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = wr_data;
        end
        if (wr_ok && (wr_ptr_q[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0])) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[rd_ptr_d[IDX_W-1:0]];
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage and head register; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        mem_q     <= mem_d;
        rd_data_q <= rd_data_d;
    end

endmodule

// File: rtl/opl_host_bus.sv
// Host bus front end for an OPL2/OPL3 register file. Host writes are queued
// and retired at chip pace: address-port writes latch the target register,
// data-port writes emit one reg_wr pulse, each followed by a minimum wait.
// Optional build macro OPL_HOST_BUSY_FLAG_EN: dout[0] reports queue/retire
// activity instead of status[0].
module opl_host_bus
    import opl2_pkg::*;
#(
    parameter int ADDR_BITS  = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WAIT  = 4,
    parameter int DATA_WAIT  = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cs_n,
    input  logic                           rd_n,
    input  logic                           wr_n,
    input  logic [ADDR_BITS-1:0]           address,
    input  logic [REG_FILE_DATA_WIDTH-1:0] din,
    output logic [REG_FILE_DATA_WIDTH-1:0] dout,
    input  logic [REG_FILE_DATA_WIDTH-1:0] status,
    output opl_reg_wr_t                    reg_wr,
    output logic                           overflow
);

    localparam int WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] ADDR_LD = CNT_W'(wait_reload(ADDR_WAIT));
    localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(wait_reload(DATA_WAIT));

    logic                           cs_n_q, cs_n_d;
    logic                           rd_n_q, rd_n_d;
    logic                           wr_n_q, wr_n_d;
    logic [ADDR_BITS-1:0]           address_q, address_d;
    logic [REG_FILE_DATA_WIDTH-1:0] din_q, din_d;
    logic                           ws_prev_q, ws_prev_d;
    logic                           rs_prev_q, rs_prev_d;
    logic                           overflow_q, overflow_d;
    logic [REG_FILE_DATA_WIDTH-1:0] dout_q, dout_d;

    opl_retire_state_t              state_q, state_d;
    logic [CNT_W-1:0]               wait_cnt_q, wait_cnt_d;
    logic [OPL_BANK_WIDTH-1:0]      addr_bank_q, addr_bank_d;
    logic [REG_FILE_ADDR_WIDTH-1:0] addr_reg_q, addr_reg_d;
    opl_reg_wr_t                    reg_wr_q, reg_wr_d;

    logic                             ws, rs, push, pop, status_rd, ovf_set;
    logic [OPL_BANK_WIDTH-1:0]        host_bank;
    opl_fifo_entry_t                  push_entry, head;
    logic [OPL_FIFO_ENTRY_WIDTH-1:0]  fifo_rd_data;
    logic                             fifo_empty, fifo_full;

    // Bank comes from the upper address bits; a single-bank part always uses bank 0.
    generate
        if (ADDR_BITS >= 2) begin : g_bank
            assign host_bank = OPL_BANK_WIDTH'(address_q[ADDR_BITS-1:1]);
        end else begin : g_no_bank
            assign host_bank = '0;
        end
    endgenerate

    assign push_entry = '{a0: address_q[0], bank: host_bank, data: din_q};
    assign head       = opl_fifo_entry_t'(fifo_rd_data);
    assign reg_wr     = reg_wr_q;
    assign overflow   = overflow_q;
    assign dout       = dout_q;

    opl_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OPL_FIFO_ENTRY_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Host strobe decode: one push per write and one clear per status read, on the leading cycle.
    always_comb begin
        cs_n_d    = cs_n;
        rd_n_d    = rd_n;
        wr_n_d    = wr_n;
        address_d = address;
        din_d     = din;
        ws        = !cs_n_q && !wr_n_q;
        rs        = !cs_n_q && !rd_n_q;
        ws_prev_d = ws;
        rs_prev_d = rs;
        push      = ws && !ws_prev_q;
        status_rd = rs && !rs_prev_q && !address_q[0];
        ovf_set   = push && fifo_full && !pop;
        // A drop in the same cycle as a status read keeps the flag set.
        overflow_d = ovf_set ? 1'b1 : (status_rd ? 1'b0 : overflow_q);
    end

    // Status byte, optionally with bit 0 replaced by the busy indication.
    always_comb begin
        dout_d = status;
`ifdef OPL_HOST_BUSY_FLAG_EN
        dout_d[0] = !fifo_empty || (state_q != RET_IDLE);
`endif
    end

    // Retire FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RET_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Retire FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RET_IDLE: if (!fifo_empty) state_d = RET_POP;
            RET_POP:  state_d = RET_WAIT;
            RET_WAIT: if (wait_cnt_q == '0) state_d = RET_IDLE;
            default:  state_d = RET_IDLE;
        endcase
    end

    // Retire FSM outputs: the head is consumed on entry to POP so that the
    // registered reg_wr pulse coincides with the POP cycle.
    always_comb begin
        pop         = (state_q == RET_IDLE) && !fifo_empty;
        wait_cnt_d  = (wait_cnt_q != '0) ? wait_cnt_q - CNT_W'(1) : '0;
        addr_bank_d = addr_bank_q;
        addr_reg_d  = addr_reg_q;
        reg_wr_d    = reg_wr_q;
        reg_wr_d.valid = 1'b0;
        if (pop) begin
            if (head.a0) begin
                reg_wr_d.valid   = 1'b1;
                reg_wr_d.bank    = addr_bank_q;
                reg_wr_d.address = addr_reg_q;
                reg_wr_d.data    = head.data;
                wait_cnt_d       = DATA_LD;
            end else begin
                addr_bank_d = head.bank;
                addr_reg_d  = head.data;
                wait_cnt_d  = ADDR_LD;
            end
        end
    end

    // Input capture, edge history, flags and status output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            address_q  <= '0;
            din_q      <= '0;
            ws_prev_q  <= 1'b0;
            rs_prev_q  <= 1'b0;
            overflow_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            address_q  <= address_d;
            din_q      <= din_d;
            ws_prev_q  <= ws_prev_d;
            rs_prev_q  <= rs_prev_d;
            overflow_q <= overflow_d;
            dout_q     <= dout_d;
        end
    end

    // Retire datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            addr_bank_q <= '0;
            addr_reg_q  <= '0;
            reg_wr_q    <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            addr_bank_q <= addr_bank_d;
            addr_reg_q  <= addr_reg_d;
            reg_wr_q    <= reg_wr_d;
        end
    end

endmodule

// File: tb/tb_opl_host_bus.sv
// Directed bench for opl_host_bus: a default instance and a shallow-queue
// instance share all host inputs.
module tb_opl_host_bus;
    import opl2_pkg::*;

`ifdef OPL_HOST_BUSY_FLAG_EN
    localparam logic BUSY_EN = 1'b1;
`else
    localparam logic BUSY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n, rd_n, wr_n;
    logic [1:0]  address;
    logic [7:0]  din, status;
    logic [7:0]  dout, dout_s;
    opl_reg_wr_t reg_wr, reg_wr_s;
    logic        overflow, overflow_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          n_big = 0, n_small = 0;
    int          big_cyc [64];
    opl_reg_wr_t big_ev [64];
    opl_reg_wr_t small_ev [64];

    always #5 clk = ~clk;

    opl_host_bus dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .address(address), .din(din), .dout(dout), .status(status),
        .reg_wr(reg_wr), .overflow(overflow)
    );

    opl_host_bus #(.FIFO_DEPTH(4)) dut_s (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .address(address), .din(din), .dout(dout_s), .status(status),
        .reg_wr(reg_wr_s), .overflow(overflow_s)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder, sampled shortly after the active edge.
    always @(posedge clk) begin
        #2;
        if (reg_wr.valid) begin
            if (n_big < 64) begin
                big_cyc[n_big] = cyc;
                big_ev[n_big]  = reg_wr;
            end
            n_big++;
        end
        if (reg_wr_s.valid) begin
            if (n_small < 64) small_ev[n_small] = reg_wr_s;
            n_small++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobe low for len cycles then high for one.
    task automatic host_write(input logic [1:0] a, input logic [7:0] d, input int len, output int t);
        cs_n = 1'b0; wr_n = 1'b0; address = a; din = d;
        t = cyc + 1;
        repeat (len) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic status_read();
        cs_n = 1'b0; rd_n = 1'b0; address = 2'b00;
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_big(input int target, input int budget, input string tag);
        int i = 0;
        while (n_big < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(n_big >= target), 32'd1);
    endtask

    task automatic burst_pairs();
        int t;
        for (int i = 0; i < 8; i++) begin
            host_write({i[0], 1'b0}, 8'(8'h20 + i), 1, t);
            host_write({i[0], 1'b1}, 8'(8'h40 + i), 1, t);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t, base, bs, k;
        reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        address = 2'b00; din = 8'h00; status = 8'hA4;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_dout", 32'(dout), 32'hA4);

        // Single address/data pair, idle latency
        base = n_big;
        host_write(2'b00, 8'hB0, 1, t);
        repeat (20) @(negedge clk);
        host_write(2'b01, 8'h31, 1, t);
        wait_big(base + 1, 10, "pair_tmo");
        repeat (40) @(negedge clk);
        check("pair_count", 32'(n_big - base), 32'd1);
        check("pair_bank", 32'(big_ev[base].bank), 32'd0);
        check("pair_addr", 32'(big_ev[base].address), 32'hB0);
        check("pair_data", 32'(big_ev[base].data), 32'h31);
        check("pair_latency", 32'(big_cyc[base] - t), 32'd2);

        // Bank select
        base = n_big;
        host_write(2'b10, 8'h05, 1, t);
        host_write(2'b11, 8'h01, 1, t);
        wait_big(base + 1, 40, "bank_tmo");
        check("bank_bank", 32'(big_ev[base].bank), 32'd1);
        check("bank_addr", 32'(big_ev[base].address), 32'h05);
        check("bank_data", 32'(big_ev[base].data), 32'h01);

        // Pacing of a back-to-back burst of 8 pairs
        do_reset();
        base = n_big;
        burst_pairs();
        check("busy_burst", 32'(dout[0]), 32'(BUSY_EN));
        wait_big(base + 8, 400, "pace_tmo");
        for (int j = 0; j < 8; j++) begin
            check($sformatf("pace_bank%0d", j), 32'(big_ev[base + j].bank), 32'(j % 2));
            check($sformatf("pace_addr%0d", j), 32'(big_ev[base + j].address), 32'(8'h20 + j));
            check($sformatf("pace_data%0d", j), 32'(big_ev[base + j].data), 32'(8'h40 + j));
            if (j > 0)
                check($sformatf("pace_gap%0d", j), 32'(big_cyc[base + j] - big_cyc[base + j - 1]), 32'd30);
        end
        repeat (40) @(negedge clk);
        check("busy_idle", 32'(dout[0]), 32'd0);

        // Overflow on the 4-deep instance: one data write occupies the
        // retire engine, then 6 more writes arrive; 4 fit, 2 are dropped.
        do_reset();
        bs = n_small;
        host_write(2'b01, 8'h90, 1, t);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 6; j++) host_write(2'b01, 8'(8'h91 + j), 1, t);
        @(negedge clk);
        check("ovf_set", 32'(overflow_s), 32'd1);
        check("ovf_big", 32'(overflow), 32'd0);
        k = 0;
        while (n_small < bs + 5 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (60) @(negedge clk);
        check("ovf_retired", 32'(n_small - bs), 32'd5);
        for (int j = 0; j < 4; j++)
            check($sformatf("ovf_data%0d", j), 32'(small_ev[bs + 1 + j].data), 32'(8'h91 + j));
        check("ovf_hold", 32'(overflow_s), 32'd1);
        status_read();
        check("ovf_clr", 32'(overflow_s), 32'd0);

        // Long write strobe yields exactly one push
        do_reset();
        base = n_big;
        host_write(2'b01, 8'h77, 10, t);
        wait_big(base + 1, 20, "long_tmo");
        repeat (60) @(negedge clk);
        check("long_count", 32'(n_big - base), 32'd1);
        check("long_data", 32'(big_ev[base].data), 32'h77);
        check("long_latency", 32'(big_cyc[base] - t), 32'd2);

        // Reset in the middle of a queued burst
        do_reset();
        base = n_big;
        burst_pairs();
        wait_big(base + 3, 200, "mid_tmo");
        check("mid_busy", 32'(dout[0]), 32'(BUSY_EN));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_reg_wr", 32'(reg_wr), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_count", 32'(n_big - base), 32'd3);
        check("mid_valid", 32'(reg_wr.valid), 32'd0);
        check("mid_dout", 32'(dout), 32'hA4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
